dmaster_st_packet_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that lets several Avalon-ST byte-stream requesters share the single channelised stream feeding the driver master's channel adapter. It grants one requester from start-of-packet to accepted end-of-packet, tags every beat with the requester index on `out_channel`, and registers the output. Downstream suppresses channels above its max_channel, so requesters are numbered 0..NUM_IN-1 from the highest-priority-reset index.

---
 rtl/dmaster_st_packet_arbiter_pkg.sv | 12 +
 rtl/dmaster_st_packet_arbiter_if.sv | 40 ++++
 rtl/dmaster_st_packet_arbiter_rr_picker.sv | 30 +++
 rtl/dmaster_st_packet_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmaster_st_packet_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmaster_st_packet_arbiter_pkg.sv
// Shared types and constants for the packet-atomic stream arbiter.
package dmaster_arb_pkg;

    localparam int BYTE_W    = 8;
    localparam int ERR_CNT_W = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

endpackage : dmaster_arb_pkg

// File: rtl/dmaster_st_packet_arbiter_if.sv
// Bundle of the requester-side and output-side Avalon-ST signals of the arbiter.
//
// Handshake: a beat moves across a link on a rising clock edge exactly when
// valid and ready are both high in the cycle before that edge. A source holds
// its data/framing stable while valid is high and ready is low. Ready may
// depend combinationally on the other side's state but never on valid.
interface dmaster_st_packet_arbiter_if #(
    parameter int NUM_IN    = 4,
    parameter int CHANNEL_W = 8
);
    import dmaster_arb_pkg::*;

    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*BYTE_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_startofpacket;
    logic [NUM_IN-1:0]        in_endofpacket;
    logic [NUM_IN-1:0]        in_ready;

    logic                     out_valid;
    logic [BYTE_W-1:0]        out_data;
    logic [CHANNEL_W-1:0]     out_channel;
    logic                     out_startofpacket;
    logic                     out_endofpacket;
    logic                     out_ready;

    // Environment side: drives the requesters and the downstream ready.
    modport master (
        output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_channel,
               out_startofpacket, out_endofpacket
    );

    // Arbiter side: sinks the requester streams, sources the channelised stream.
    modport slave (
        input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_channel,
               out_startofpacket, out_endofpacket
    );

endinterface : dmaster_st_packet_arbiter_if

// File: rtl/dmaster_st_packet_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping from NUM_IN-1 back to 0.
module dmaster_rr_picker #(
    parameter int NUM_IN = 4,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [PTR_W-1:0]  idx_o,
    output logic              any_o
);

    // Scan offsets from farthest to nearest so the nearest request wins last.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int off = NUM_IN - 1; off >= 0; off--) begin
            int cand;
            cand = int'(ptr_i) + off;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            if (req_i[cand]) begin
                idx_o = PTR_W'(cand);
                any_o = 1'b1;
            end
        end
    end

endmodule : dmaster_rr_picker

// File: rtl/dmaster_st_packet_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_IN byte streams into one
// channelised stream. A requester keeps the grant from its first beat until
// its end-of-packet beat is accepted; every beat carries the requester index
// on out_channel. The output is a one-entry register.
// Optional framing checker: define DMASTER_ARB_FRAMING_CHECK_EN.
module dmaster_st_packet_arbiter
    import dmaster_arb_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int CHANNEL_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    dmaster_st_packet_arbiter_if.slave bus,
    output logic                    framing_error,
    output logic [ERR_CNT_W-1:0]    framing_err_count,
    output arb_state_e              dbg_state_o
);

    localparam int PTR_W = $clog2(NUM_IN);

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("dmaster_st_packet_arbiter: NUM_IN must be 2..16");
    end
    if (CHANNEL_W < 5 && NUM_IN > (1 << CHANNEL_W)) begin : g_bad_channel_w
        $error("dmaster_st_packet_arbiter: CHANNEL_W too narrow for NUM_IN");
    end

    arb_state_e           state_q;
    logic [PTR_W-1:0]     grant_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     rr_ptr_d;
    logic                 out_valid_q;
    logic [BYTE_W-1:0]    out_data_q;
    logic [CHANNEL_W-1:0] out_chan_q;
    logic                 out_sop_q;
    logic                 out_eop_q;

    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 out_room;
    logic                 grant_start;
    logic                 beat_acc;
    logic [NUM_IN-1:0]    in_ready_c;
    logic [BYTE_W-1:0]    g_data;
    logic                 g_sop;
    logic                 g_eop;

    dmaster_rr_picker #(
        .NUM_IN (NUM_IN),
        .PTR_W  (PTR_W)
    ) u_picker (
        .req_i  (bus.in_valid),
        .ptr_i  (rr_ptr_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // The output register can take a beat when empty or being drained this cycle.
    assign out_room    = ~out_valid_q | bus.out_ready;
    assign grant_start = (state_q == IDLE) & pick_any;
    assign g_data      = bus.in_data[int'(grant_q)*BYTE_W +: BYTE_W];
    assign g_sop       = bus.in_startofpacket[grant_q];
    assign g_eop       = bus.in_endofpacket[grant_q];
    assign beat_acc    = (state_q == GRANTED) & bus.in_valid[grant_q] & out_room;

    // Only the granted requester sees ready, and only while the output can accept.
    always_comb begin
        in_ready_c = '0;
        if (state_q == GRANTED) begin
            in_ready_c[grant_q] = out_room;
        end
    end

    // Pointer moves one past the requester whose packet just finished.
    always_comb begin
        rr_ptr_d = grant_q + 1'b1;
        if (grant_q == PTR_W'(NUM_IN - 1)) begin
            rr_ptr_d = '0;
        end
    end

    // Arbitration FSM together with the one-entry output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state_q <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (beat_acc && g_eop) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (beat_acc) begin
                out_valid_q <= 1'b1;
                out_data_q  <= g_data;
                out_chan_q  <= CHANNEL_W'(grant_q);
                out_sop_q   <= g_sop;
                out_eop_q   <= g_eop;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef DMASTER_ARB_FRAMING_CHECK_EN
    logic                 first_q;
    logic                 ferr_q;
    logic [ERR_CNT_W-1:0] fcnt_q;
    logic                 frame_bad;

    // First beat of a grant must carry SOP; later beats must not.
    assign frame_bad = beat_acc & (first_q ? ~g_sop : g_sop);

    // Track first-beat position and accumulate framing errors (count saturates).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= 1'b0;
            ferr_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            if (grant_start) begin
                first_q <= 1'b1;
            end else if (beat_acc) begin
                first_q <= 1'b0;
            end
            if (frame_bad) begin
                ferr_q <= 1'b1;
                if (fcnt_q != '1) begin
                    fcnt_q <= fcnt_q + 1'b1;
                end
            end
        end
    end

    assign framing_error     = ferr_q;
    assign framing_err_count = fcnt_q;
`else
    logic unused_grant_start;
    assign unused_grant_start = grant_start;
    assign framing_error      = 1'b0;
    assign framing_err_count  = '0;
`endif

    assign bus.in_ready          = in_ready_c;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_data_q;
    assign bus.out_channel       = out_chan_q;
    assign bus.out_startofpacket = out_sop_q;
    assign bus.out_endofpacket   = out_eop_q;
    assign dbg_state_o           = state_q;

endmodule : dmaster_st_packet_arbiter

// File: tb/tb_dmaster_st_packet_arbiter.sv
// Directed bench for dmaster_st_packet_arbiter: per-requester beat sources,
// output scoreboard, timing checks on accept/output cycles.
module tb_dmaster_st_packet_arbiter;
    import dmaster_arb_pkg::*;

    localparam int N  = 4;
    localparam int CW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmaster_st_packet_arbiter_if #(.NUM_IN(N), .CHANNEL_W(CW)) bus ();
    logic             framing_error;
    logic [7:0]       framing_err_count;
    arb_state_e       dbg_state;

    dmaster_st_packet_arbiter #(.NUM_IN(N), .CHANNEL_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .framing_error     (framing_error),
        .framing_err_count (framing_err_count),
        .dbg_state_o       (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- sources ----------------
    logic [9:0] src_mem [N][16];   // {sop, eop, data}
    int         src_len [N];
    int         src_pos [N];
    logic [N-1:0] acc_mask;

    always_comb begin
        bus.in_valid         = '0;
        bus.in_data          = '0;
        bus.in_startofpacket = '0;
        bus.in_endofpacket   = '0;
        for (int i = 0; i < N; i++) begin
            if (src_pos[i] < src_len[i]) begin
                bus.in_valid[i]          = 1'b1;
                bus.in_startofpacket[i]  = src_mem[i][src_pos[i]][9];
                bus.in_endofpacket[i]    = src_mem[i][src_pos[i]][8];
                bus.in_data[8*i +: 8]    = src_mem[i][src_pos[i]][7:0];
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) src_pos[i] = src_pos[i] + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];          // {channel, sop, eop, data}
    int n_chk = 0;
    int n_bad = 0;
    int acc_cyc [64];
    int out_cyc [64];
    int acc_cnt = 0;
    int out_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always begin
        @(negedge clk);
        acc_mask = '0;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (bus.in_valid[i] && bus.in_ready[i]) begin
                    acc_mask[i] = 1'b1;
                    if (acc_cnt < 64) acc_cyc[acc_cnt] = cyc;
                    acc_cnt++;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                logic [17:0] got;
                got = {bus.out_channel, bus.out_startofpacket, bus.out_endofpacket, bus.out_data};
                if (out_cnt < 64) out_cyc[out_cnt] = cyc;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("beat_extra", exp_q.size(), 1);
                end else begin
                    check("beat", 32'(got), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
    endtask

    task automatic load_beat(input int r, input logic sop, input logic eop, input logic [7:0] d);
        src_mem[r][src_len[r]] = {sop, eop, d};
        src_len[r] = src_len[r] + 1;
    endtask

    task automatic push_exp(input int ch, input logic sop, input logic eop, input logic [7:0] d);
        exp_q.push_back({CW'(ch), sop, eop, d});
    endtask

    task automatic reset_on();
        @(posedge clk); #2;
        reset = 1'b1;
        clear_src();
        exp_q.delete();
        acc_cnt = 0;
        out_cnt = 0;
    endtask

    task automatic reset_off();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    function automatic bit drained();
        bit d;
        d = (exp_q.size() == 0);
        for (int i = 0; i < N; i++) if (src_pos[i] < src_len[i]) d = 1'b0;
        return d;
    endfunction

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (!drained() && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        check({tag, "_drain"}, 32'(drained()), 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t_raise;
        int n;
        reset        = 1'b1;
        bus.out_ready = 1'b1;
        acc_mask     = '0;
        clear_src();
        repeat (3) @(posedge clk);
        #2;

        // Reset values
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data",  32'(bus.out_data), 0);
        check("rst_out_chan",  32'(bus.out_channel), 0);
        check("rst_out_sop",   32'(bus.out_startofpacket), 0);
        check("rst_out_eop",   32'(bus.out_endofpacket), 0);
        check("rst_in_ready",  32'(bus.in_ready), 0);
        check("rst_ferr",      32'(framing_error), 0);
        check("rst_fcnt",      32'(framing_err_count), 0);

        // T1: requester 0, 4-beat packet 0x11..0x14
        reset = 1'b0;
        @(posedge clk); #2;
        for (int k = 0; k < 4; k++) begin
            load_beat(0, k == 0, k == 3, 8'h11 + 8'(k));
            push_exp(0, k == 0, k == 3, 8'h11 + 8'(k));
        end
        t_raise = cyc;
        wait_drain("t1");
        check("t1_arb_lat", 32'(acc_cyc[0] - t_raise), 1);
        check("t1_out_lat", 32'(out_cyc[0] - acc_cyc[0]), 1);
        check("t1_b2b",     32'(out_cyc[3] - out_cyc[0]), 3);

        // T2: requesters 0 and 2, two 2-beat packets each, valid from reset
        reset_on();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 2; k++) begin
                load_beat(0, k == 0, k == 1, 8'h01 + 8'(2*p + k));
                load_beat(2, k == 0, k == 1, 8'h21 + 8'(2*p + k));
            end
        end
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 2; k++) push_exp(0, k == 0, k == 1, 8'h01 + 8'(2*p + k));
            for (int k = 0; k < 2; k++) push_exp(2, k == 0, k == 1, 8'h21 + 8'(2*p + k));
        end
        reset_off();
        wait_drain("t2");
        for (int k = 0; k < 7; k++) begin
            check($sformatf("t2_gap%0d", k), 32'(acc_cyc[k+1] - acc_cyc[k]), (k % 2 == 0) ? 1 : 2);
        end

        // T3: requester 1, backpressure for 3 cycles mid-packet
        reset_on();
        for (int k = 0; k < 4; k++) begin
            load_beat(1, k == 0, k == 3, 8'h31 + 8'(k));
            push_exp(1, k == 0, k == 3, 8'h31 + 8'(k));
        end
        reset_off();
        n = 0;
        while (out_cnt < 1 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("t3_first_out", 32'(out_cnt), 1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(bus.out_valid), 1);
            check("t3_hold_data",  32'(bus.out_data), 32'h32);
            check("t3_in_ready1",  32'(bus.in_ready[1]), 0);
        end
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        wait_drain("t3");

        // T4: single-beat packets on all requesters, two rounds
        reset_on();
        for (int r = 0; r < N; r++) begin
            load_beat(r, 1'b1, 1'b1, 8'h40 + 8'(r));
            load_beat(r, 1'b1, 1'b1, 8'h48 + 8'(r));
        end
        for (int r = 0; r < N; r++) push_exp(r, 1'b1, 1'b1, 8'h40 + 8'(r));
        for (int r = 0; r < N; r++) push_exp(r, 1'b1, 1'b1, 8'h48 + 8'(r));
        reset_off();
        wait_drain("t4");
        check("t4_gap", 32'(acc_cyc[4] - acc_cyc[3]), 2);

        // T5: reset mid-packet, then rearbitration restarts at requester 0
        reset_on();
        load_beat(1, 1'b1, 1'b1, 8'h1F);
        push_exp(1, 1'b1, 1'b1, 8'h1F);
        reset_off();
        wait_drain("t5a");
        for (int k = 0; k < 5; k++) load_beat(2, k == 0, k == 4, 8'h51 + 8'(k));
        push_exp(2, 1'b1, 1'b0, 8'h51);
        n = 0;
        while (src_pos[2] < 2 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        reset = 1'b1;
        #1;
        check("t5_out_valid", 32'(bus.out_valid), 0);
        check("t5_out_data",  32'(bus.out_data), 0);
        check("t5_out_chan",  32'(bus.out_channel), 0);
        check("t5_out_sop",   32'(bus.out_startofpacket), 0);
        check("t5_out_eop",   32'(bus.out_endofpacket), 0);
        check("t5_in_ready",  32'(bus.in_ready), 0);
        check("t5_flush",     32'(exp_q.size()), 0);
        clear_src();
        exp_q.delete();
        load_beat(3, 1'b1, 1'b1, 8'h3A);
        load_beat(0, 1'b1, 1'b1, 8'h0A);
        push_exp(0, 1'b1, 1'b1, 8'h0A);
        push_exp(3, 1'b1, 1'b1, 8'h3A);
        reset_off();
        wait_drain("t5b");

        // T6: malformed framing: first beat without SOP, then an extra SOP
        reset_on();
        load_beat(0, 1'b0, 1'b0, 8'h61);
        load_beat(0, 1'b1, 1'b0, 8'h62);
        load_beat(0, 1'b0, 1'b1, 8'h63);
        push_exp(0, 1'b0, 1'b0, 8'h61);
        push_exp(0, 1'b1, 1'b0, 8'h62);
        push_exp(0, 1'b0, 1'b1, 8'h63);
        reset_off();
        wait_drain("t6");
`ifdef DMASTER_ARB_FRAMING_CHECK_EN
        check("t6_ferr", 32'(framing_error), 1);
        check("t6_fcnt", 32'(framing_err_count), 2);
`else
        check("t6_ferr", 32'(framing_error), 0);
        check("t6_fcnt", 32'(framing_err_count), 0);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_dmaster_st_packet_arbiter
